// File: rtl/jam_pkg.sv
// Shared definitions for the exhaustive assignment search: FSM state encoding
// and a constant-evaluable ceiling-log2 used to size index fields.
package jam_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CAL,
    CMP,
    FIND_PNT,
    FIND_CPNT,
    SWAP,
    REV,
    DONE
  } state_t;

  // Never returns less than 1 so that N=2 still gets a one-bit index.
  function automatic int clog2(input int value);
    int width;
    width = 1;
    while ((1 << width) < value) width++;
    return width;
  endfunction

endpackage

// File: rtl/jam_perm_step.sv
// Permutation register file plus the lexicographic next-permutation steps
// (pivot scan, successor scan, swap, suffix reversal), sequenced by jam_n's state.
module jam_perm_step
  import jam_pkg::*;
#(
  parameter int N  = 8,
  parameter int IW = 3
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            init,
  input  state_t          state,
  output logic [N*IW-1:0] perm_flat,
  output logic            pnt_hit,
  output logic            pnt_end,
  output logic            cpnt_hit
);

  localparam logic [IW-1:0] ONE     = IW'(1);
  localparam logic [IW-1:0] START_I = IW'(N - 2);
  localparam logic [IW-1:0] START_J = IW'(N - 1);

  logic [IW-1:0] perm [N];
  logic [IW-1:0] idx_i;
  logic [IW-1:0] idx_j;

  always_comb begin
    perm_flat = '0;
    for (int k = 0; k < N; k++) perm_flat[k*IW +: IW] = perm[k];
  end

  assign pnt_hit  = (state == FIND_PNT) && (perm[idx_i] < perm[idx_i + ONE]);
  assign pnt_end  = (state == FIND_PNT) && !pnt_hit && (idx_i == '0);
  assign cpnt_hit = (state == FIND_CPNT) && (perm[idx_j] > perm[idx_i]);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int k = 0; k < N; k++) perm[k] <= IW'(k);
      idx_i <= START_I;
      idx_j <= START_J;
    end else if (init) begin
      for (int k = 0; k < N; k++) perm[k] <= IW'(k);
      idx_i <= START_I;
      idx_j <= START_J;
    end else begin
      case (state)
        CMP: begin
          idx_i <= START_I;
          idx_j <= START_J;
        end
        FIND_PNT: if (!pnt_hit && idx_i != '0) idx_i <= idx_i - ONE;
        FIND_CPNT: if (!cpnt_hit) idx_j <= idx_j - ONE;
        SWAP: begin
          perm[idx_i] <= perm[idx_j];
          perm[idx_j] <= perm[idx_i];
        end
        // Suffix after the pivot is descending; mirroring it makes it ascending.
        REV: begin
          for (int k = 0; k < N; k++)
            if (k > int'(idx_i)) perm[k] <= perm[IW'(N + int'(idx_i) - k)];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/jam_n.sv
// Exhaustive N-worker/N-job assignment search: walks every permutation in
// lexicographic order, sums its costs and keeps the min (or max) total.
module jam_n
  import jam_pkg::*;
#(
  parameter  int N   = 8,
  parameter  int CW  = 7,
  parameter  int SW  = 10,
  parameter  int MCW = 16,
  localparam int IW  = clog2(N)
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            start,
  input  logic            mode,
  output logic [IW-1:0]   W,
  output logic [IW-1:0]   J,
  input  logic [CW-1:0]   Cost,
  output logic [SW-1:0]   BestCost,
  output logic [MCW-1:0]  MatchCount,
  output logic [N*IW-1:0] BestPerm,
  output logic            busy,
  output logic            Valid
);

  localparam logic [IW-1:0] ONE    = IW'(1);
  localparam logic [IW-1:0] LAST_W = IW'(N - 1);

  state_t          state;
  logic [1:0]      rst_sync;
  logic            ready;
  logic            accept;
  logic            mode_q;
  logic            first;
  logic            better;
  logic [SW-1:0]   sum;
  logic [N*IW-1:0] perm_flat;
  logic [IW-1:0]   perm_v [N];
  logic            pnt_hit;
  logic            pnt_end;
  logic            cpnt_hit;

  // Starts are held off until two clean edges have passed after reset release.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  assign ready  = rst_sync[1];
  assign accept = start && ready && (state == IDLE || state == DONE);
  assign better = mode_q ? (sum > BestCost) : (sum < BestCost);

  always_comb begin
    for (int k = 0; k < N; k++) perm_v[k] = perm_flat[k*IW +: IW];
  end

  jam_perm_step #(.N(N), .IW(IW)) u_step (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .init     (accept),
    .state    (state),
    .perm_flat(perm_flat),
    .pnt_hit  (pnt_hit),
    .pnt_end  (pnt_end),
    .cpnt_hit (cpnt_hit)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= IDLE;
      sum        <= '0;
      mode_q     <= 1'b0;
      first      <= 1'b0;
      W          <= '0;
      J          <= '0;
      BestCost   <= '0;
      MatchCount <= '0;
      BestPerm   <= '0;
      busy       <= 1'b0;
      Valid      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            state  <= CAL;
            sum    <= '0;
            mode_q <= mode;
            first  <= 1'b1;
            W      <= '0;
            J      <= '0;
            busy   <= 1'b1;
            Valid  <= 1'b0;
          end
        end
        // J is looked up one cycle ahead so Cost always matches the driven pair.
        CAL: begin
          sum <= sum + SW'(Cost);
          if (W == LAST_W) begin
            W     <= '0;
            J     <= '0;
            state <= CMP;
          end else begin
            W <= W + ONE;
            J <= perm_v[W + ONE];
          end
        end
        CMP: begin
          if (first || better) begin
            BestCost   <= sum;
            MatchCount <= MCW'(1);
            BestPerm   <= perm_flat;
          end else if (sum == BestCost && MatchCount != '1) begin
            MatchCount <= MatchCount + MCW'(1);
          end
          first <= 1'b0;
          sum   <= '0;
          state <= FIND_PNT;
        end
        FIND_PNT: begin
          if (pnt_hit) begin
            state <= FIND_CPNT;
          end else if (pnt_end) begin
            state <= DONE;
            busy  <= 1'b0;
            Valid <= 1'b1;
          end
        end
        FIND_CPNT: if (cpnt_hit) state <= SWAP;
        SWAP: state <= REV;
        REV: begin
          state <= CAL;
          J     <= perm_v[0];
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jam_n.sv
// Self-checking bench for jam_n: three instances (N=3 with a 2-bit match
// counter, N=4, N=6) checked against a brute-force assignment model.
module tb_jam_n;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       mode = 1'b0;
  logic [2:0] start_v = 3'b000;

  int cm [8][8];
  int checks = 0;
  int errors = 0;

  int n_of   [3] = '{3, 4, 6};
  int iw_of  [3] = '{2, 2, 3};
  int mcw_of [3] = '{2, 16, 16};

  logic [1:0]  w3, j3, w4, j4;
  logic [2:0]  w6, j6;
  logic [6:0]  cost3, cost4, cost6;
  logic [9:0]  bc3, bc4, bc6;
  logic [1:0]  mc3;
  logic [15:0] mc4, mc6;
  logic [5:0]  bp3;
  logic [7:0]  bp4;
  logic [17:0] bp6;
  logic        busy3, busy4, busy6, valid3, valid4, valid6;

  int   obs_bc, obs_mc, obs_bp, obs_w, obs_j;
  logic obs_valid, obs_busy;

  always #5 CLK = ~CLK;

  assign cost3 = 7'(cm[3'(w3)][3'(j3)]);
  assign cost4 = 7'(cm[3'(w4)][3'(j4)]);
  assign cost6 = 7'(cm[w6][j6]);

  jam_n #(.N(3), .CW(7), .SW(10), .MCW(2)) dut3 (
    .CLK(CLK), .RST_N(RST_N), .start(start_v[0]), .mode(mode), .W(w3), .J(j3),
    .Cost(cost3), .BestCost(bc3), .MatchCount(mc3), .BestPerm(bp3), .busy(busy3), .Valid(valid3));

  jam_n #(.N(4), .CW(7), .SW(10), .MCW(16)) dut4 (
    .CLK(CLK), .RST_N(RST_N), .start(start_v[1]), .mode(mode), .W(w4), .J(j4),
    .Cost(cost4), .BestCost(bc4), .MatchCount(mc4), .BestPerm(bp4), .busy(busy4), .Valid(valid4));

  jam_n #(.N(6), .CW(7), .SW(10), .MCW(16)) dut6 (
    .CLK(CLK), .RST_N(RST_N), .start(start_v[2]), .mode(mode), .W(w6), .J(j6),
    .Cost(cost6), .BestCost(bc6), .MatchCount(mc6), .BestPerm(bp6), .busy(busy6), .Valid(valid6));

  function automatic int fact(input int n);
    int r;
    r = 1;
    for (int k = 2; k <= n; k++) r *= n - k + 2;
    return r;
  endfunction

  function automatic int pack_perm(input int p [8], input int n, input int iw);
    int r;
    r = 0;
    for (int k = 0; k < n; k++) r |= p[k] << (k * iw);
    return r;
  endfunction

  // Brute force over all n^n job tuples in ascending numeric order; the
  // permutations among them appear in lexicographic order.
  function automatic void ref_model(input int n, input bit md, input int mcw,
                                    output int best, output int cnt, output int bperm [8]);
    int total, v, s, used;
    int d [8];
    bit ok, first;
    total = 1;
    for (int k = 0; k < n; k++) total *= n;
    first = 1'b1;
    best = 0;
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      bperm[k] = 0;
      d[k] = 0;
    end
    for (int t = 0; t < total; t++) begin
      v = t;
      for (int k = n - 1; k >= 0; k--) begin
        d[k] = v % n;
        v = v / n;
      end
      used = 0;
      ok = 1'b1;
      s = 0;
      for (int k = 0; k < n; k++) begin
        if (((used >> d[k]) & 1) != 0) ok = 1'b0;
        used |= 1 << d[k];
        s += cm[k][d[k]];
      end
      if (ok) begin
        if (first || (md ? (s > best) : (s < best))) begin
          best = s;
          cnt = 1;
          for (int k = 0; k < 8; k++) bperm[k] = d[k];
          first = 1'b0;
        end else if (s == best) begin
          cnt++;
        end
      end
    end
    if (cnt > (1 << mcw) - 1) cnt = (1 << mcw) - 1;
  endfunction

  task automatic grab(input int sel);
    case (sel)
      0: begin
        obs_bc = int'(bc3); obs_mc = int'(mc3); obs_bp = int'(bp3);
        obs_w = int'(w3); obs_j = int'(j3); obs_valid = valid3; obs_busy = busy3;
      end
      1: begin
        obs_bc = int'(bc4); obs_mc = int'(mc4); obs_bp = int'(bp4);
        obs_w = int'(w4); obs_j = int'(j4); obs_valid = valid4; obs_busy = busy4;
      end
      default: begin
        obs_bc = int'(bc6); obs_mc = int'(mc6); obs_bp = int'(bp6);
        obs_w = int'(w6); obs_j = int'(j6); obs_valid = valid6; obs_busy = busy6;
      end
    endcase
  endtask

  task automatic pulse_start(input int sel);
    start_v[sel] = 1'b1;
    @(posedge CLK);
    #1 start_v[sel] = 1'b0;
  endtask

  task automatic wait_valid(input int sel, output int cycles);
    int limit;
    limit = fact(n_of[sel]) * (2 * n_of[sel] + 3) + 8;
    cycles = 0;
    grab(sel);
    while (!obs_valid && cycles < limit) begin
      @(posedge CLK);
      #1;
      cycles++;
      grab(sel);
    end
    if (!obs_valid) begin
      checks++;
      errors++;
      $display("[TB] FAIL timeout_n%0d: Valid=%0b after %0d cycles, want 1", n_of[sel], obs_valid, cycles);
    end
  endtask

  task automatic set_diag();
    for (int w = 0; w < 8; w++)
      for (int j = 0; j < 8; j++) cm[w][j] = (w == j) ? 0 : 10;
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    start_v = 3'b000;
    mode = 1'b0;
    for (int w = 0; w < 8; w++)
      for (int j = 0; j < 8; j++) cm[w][j] = 1;
    repeat (2) @(posedge CLK);
    #1;
    grab(1);
    checks++; if (obs_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %0b want 0", obs_valid); end
    checks++; if (obs_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %0b want 0", obs_busy); end
    checks++; if (obs_bc !== 0) begin errors++; $display("[TB] FAIL reset_bestcost: got %0d want 0", obs_bc); end
    checks++; if (obs_mc !== 0) begin errors++; $display("[TB] FAIL reset_matchcount: got %0d want 0", obs_mc); end
    checks++; if (obs_bp !== 0) begin errors++; $display("[TB] FAIL reset_bestperm: got %0d want 0", obs_bp); end
    checks++; if (obs_w !== 0 || obs_j !== 0) begin errors++; $display("[TB] FAIL reset_wj: got W=%0d J=%0d want 0/0", obs_w, obs_j); end
    // A start on the very first edge after release must be ignored.
    RST_N = 1'b1;
    pulse_start(1);
    grab(1);
    checks++; if (obs_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_early_start: busy=%0b want 0", obs_busy); end
    repeat (2) @(posedge CLK);
    #1;
  endtask

  task automatic test_const_cost();
    int cyc;
    mode = 1'b0;
    pulse_start(1);
    grab(1);
    checks++; if (obs_busy !== 1'b1 || obs_valid !== 1'b0) begin errors++; $display("[TB] FAIL run_flags: busy=%0b valid=%0b want 1/0", obs_busy, obs_valid); end
    wait_valid(1, cyc);
    grab(1);
    checks++; if (obs_bc !== 4) begin errors++; $display("[TB] FAIL const4_cost: got %0d want 4", obs_bc); end
    checks++; if (obs_mc !== 24) begin errors++; $display("[TB] FAIL const4_count: got %0d want 24", obs_mc); end
    checks++; if (obs_bp !== 228) begin errors++; $display("[TB] FAIL const4_perm: got %0d want 228", obs_bp); end
    checks++; if (obs_valid !== 1'b1 || obs_busy !== 1'b0) begin errors++; $display("[TB] FAIL const4_done: valid=%0b busy=%0b want 1/0", obs_valid, obs_busy); end
    checks++; if (obs_w !== 0 || obs_j !== 0) begin errors++; $display("[TB] FAIL done_wj: got W=%0d J=%0d want 0/0", obs_w, obs_j); end
    pulse_start(0);
    wait_valid(0, cyc);
    grab(0);
    checks++; if (obs_bc !== 3) begin errors++; $display("[TB] FAIL const3_cost: got %0d want 3", obs_bc); end
    checks++; if (obs_mc !== 3) begin errors++; $display("[TB] FAIL const3_saturate: got %0d want 3", obs_mc); end
    checks++; if (obs_bp !== 36) begin errors++; $display("[TB] FAIL const3_perm: got %0d want 36", obs_bp); end
  endtask

  task automatic test_diagonal();
    int cyc;
    set_diag();
    mode = 1'b0;
    pulse_start(1);
    wait_valid(1, cyc);
    grab(1);
    checks++; if (obs_bc !== 0) begin errors++; $display("[TB] FAIL diag_min_cost: got %0d want 0", obs_bc); end
    checks++; if (obs_mc !== 1) begin errors++; $display("[TB] FAIL diag_min_count: got %0d want 1", obs_mc); end
    checks++; if (obs_bp !== 228) begin errors++; $display("[TB] FAIL diag_min_perm: got %0d want 228", obs_bp); end
    checks++; if (cyc > 24 * 11) begin errors++; $display("[TB] FAIL diag_latency: got %0d cycles want <= 264", cyc); end
    mode = 1'b1;
    pulse_start(1);
    wait_valid(1, cyc);
    grab(1);
    checks++; if (obs_bc !== 40) begin errors++; $display("[TB] FAIL diag_max_cost: got %0d want 40", obs_bc); end
    checks++; if (obs_mc !== 9) begin errors++; $display("[TB] FAIL diag_max_count: got %0d want 9", obs_mc); end
    checks++; if (obs_bp !== 177) begin errors++; $display("[TB] FAIL diag_max_perm: got %0d want 177", obs_bp); end
  endtask

  task automatic test_product_max();
    int cyc;
    for (int w = 0; w < 8; w++)
      for (int j = 0; j < 8; j++) cm[w][j] = w * j;
    mode = 1'b1;
    pulse_start(2);
    wait_valid(2, cyc);
    grab(2);
    checks++; if (obs_bc !== 55) begin errors++; $display("[TB] FAIL prod6_cost: got %0d want 55", obs_bc); end
    checks++; if (obs_mc !== 1) begin errors++; $display("[TB] FAIL prod6_count: got %0d want 1", obs_mc); end
    checks++; if (obs_bp !== 181896) begin errors++; $display("[TB] FAIL prod6_perm: got %0d want 181896", obs_bp); end
    checks++; if (cyc > 720 * 15) begin errors++; $display("[TB] FAIL prod6_latency: got %0d cycles want <= 10800", cyc); end
  endtask

  task automatic test_start_ignored();
    int cyc;
    set_diag();
    mode = 1'b0;
    pulse_start(1);
    repeat (2) @(posedge CLK);
    #1 mode = 1'b1;
    pulse_start(1);
    mode = 1'b0;
    wait_valid(1, cyc);
    grab(1);
    checks++; if (obs_bc !== 0) begin errors++; $display("[TB] FAIL midstart_cost: got %0d want 0", obs_bc); end
    checks++; if (obs_mc !== 1) begin errors++; $display("[TB] FAIL midstart_count: got %0d want 1", obs_mc); end
  endtask

  task automatic test_reset_midrun();
    int cyc;
    set_diag();
    mode = 1'b1;
    pulse_start(1);
    repeat (30) @(posedge CLK);
    #1 RST_N = 1'b0;
    #2;
    grab(1);
    checks++; if (obs_valid !== 1'b0 || obs_busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_flags: valid=%0b busy=%0b want 0/0", obs_valid, obs_busy); end
    checks++; if (obs_bc !== 0 || obs_mc !== 0 || obs_bp !== 0) begin errors++; $display("[TB] FAIL abort_results: cost=%0d count=%0d perm=%0d want 0/0/0", obs_bc, obs_mc, obs_bp); end
    @(posedge CLK);
    #1 RST_N = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    pulse_start(1);
    wait_valid(1, cyc);
    grab(1);
    checks++; if (obs_bc !== 40 || obs_mc !== 9 || obs_bp !== 177) begin errors++; $display("[TB] FAIL rerun_after_abort: cost=%0d count=%0d perm=%0d want 40/9/177", obs_bc, obs_mc, obs_bp); end
  endtask

  task automatic test_random();
    int sels [8] = '{0, 0, 0, 0, 1, 1, 2, 2};
    int sel, n, cyc, exp_bc, exp_mc, exp_bp;
    int exp_perm [8];
    for (int r = 0; r < 8; r++) begin
      sel = sels[r];
      n = n_of[sel];
      for (int w = 0; w < 8; w++)
        for (int j = 0; j < 8; j++) cm[w][j] = int'($urandom_range(0, 127));
      mode = r[0];
      pulse_start(sel);
      wait_valid(sel, cyc);
      grab(sel);
      ref_model(n, r[0], mcw_of[sel], exp_bc, exp_mc, exp_perm);
      exp_bp = pack_perm(exp_perm, n, iw_of[sel]);
      checks++; if (obs_bc !== exp_bc) begin errors++; $display("[TB] FAIL rand%0d_n%0d_cost: got %0d want %0d", r, n, obs_bc, exp_bc); end
      checks++; if (obs_mc !== exp_mc) begin errors++; $display("[TB] FAIL rand%0d_n%0d_count: got %0d want %0d", r, n, obs_mc, exp_mc); end
      checks++; if (obs_bp !== exp_bp) begin errors++; $display("[TB] FAIL rand%0d_n%0d_perm: got %0d want %0d", r, n, obs_bp, exp_bp); end
      checks++; if (cyc > fact(n) * (2 * n + 3)) begin errors++; $display("[TB] FAIL rand%0d_n%0d_latency: got %0d want <= %0d", r, n, cyc, fact(n) * (2 * n + 3)); end
    end
  endtask

  initial begin
    test_reset();
    test_const_cost();
    test_diagonal();
    test_product_max();
    test_start_ignored();
    test_reset_midrun();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
